// File: rtl/home_sensor_conditioner.sv
// home_sensor_conditioner: motion sync/debounce/hold-off and daylight hysteresis with sample confirmation
module home_sensor_conditioner #(
  parameter int          SYNC_STAGES     = 2,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter int          HOLD_CYCLES     = 1000,
  parameter logic [7:0]  DAY_ON_THRESH   = 8'd160,
  parameter logic [7:0]  DAY_OFF_THRESH  = 8'd96,
  parameter int          DAY_CONFIRM     = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       motion_raw,
  input  logic [7:0] light_level,
  input  logic       sample_valid,
  output logic       motion,
  output logic       motion_pulse,
  output logic       daylight
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int CW = $clog2(DAY_CONFIRM + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] CONF_LAST = CW'(DAY_CONFIRM - 1);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DW-1:0]          db_cnt_q, db_cnt_d;
  logic                   filt_q, filt_d;
  logic [1:0]             state_q, state_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic                   motion_q, motion_d;
  logic                   pulse_q, pulse_d;
  logic [CW-1:0]          conf_q, conf_d;
  logic                   day_q, day_d;
  logic                   m_sync, qual, hit;

  assign m_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], motion_raw};
    db_cnt_d = (m_sync == filt_q || db_cnt_q == DB_LAST) ? '0 : db_cnt_q + 1'b1;
    filt_d   = (m_sync != filt_q && db_cnt_q == DB_LAST) ? m_sync : filt_q;
  end

  // A rise of filt while holding retriggers straight back to ACTIVE without a pulse
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: if (filt_q) begin
        state_d = ACTIVE;
        pulse_d = 1'b1;
      end
      ACTIVE: if (!filt_q) begin
        state_d = HOLD;
        hold_d  = HOLD_LOAD;
      end
      HOLD: if (filt_q) state_d = ACTIVE;
        else if (hold_q == '0) state_d = IDLE;
        else hold_d = hold_q - 1'b1;
      default: state_d = IDLE;
    endcase
    motion_d = (state_d != IDLE);
  end

  always_comb begin
    qual   = day_q ? (light_level <= DAY_OFF_THRESH) : (light_level >= DAY_ON_THRESH);
    hit    = sample_valid && qual && conf_q == CONF_LAST;
    conf_d = !sample_valid ? conf_q : (!qual || hit) ? '0 : conf_q + 1'b1;
    day_d  = hit ? !day_q : day_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= '0;
      db_cnt_q <= '0;
      filt_q   <= 1'b0;
      state_q  <= IDLE;
      hold_q   <= '0;
      motion_q <= 1'b0;
      pulse_q  <= 1'b0;
      conf_q   <= '0;
      day_q    <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      db_cnt_q <= db_cnt_d;
      filt_q   <= filt_d;
      state_q  <= state_d;
      hold_q   <= hold_d;
      motion_q <= motion_d;
      pulse_q  <= pulse_d;
      conf_q   <= conf_d;
      day_q    <= day_d;
    end
  end

  assign motion       = motion_q;
  assign motion_pulse = pulse_q;
  assign daylight     = day_q;
endmodule
